// File: rtl/mprjram_arb_pkg.sv
// Shared types and constants for the user-project BRAM arbiter and its wait counter.
package mprjram_arb_pkg;

  localparam int DATA_W = 32;
  localparam logic [7:0] BRAM_BASE_HI = 8'h38;

  typedef enum logic [1:0] {IDLE, BUSY_WB, BUSY_ACC, DONE} arb_state_t;
  typedef enum logic {OWN_WB, OWN_ACC} owner_t;

  // A read drives no byte enables, so a zero mask doubles as "not a write".
  function automatic logic [3:0] we_mask(input logic we, input logic [3:0] sel);
    return we ? sel : 4'h0;
  endfunction

endpackage

// File: rtl/mprjram_wait_cnt.sv
// Loadable down-counter: after load, tc pulses on the DELAYS-th cycle (counting the first cycle as 1).
module mprjram_wait_cnt #(
  parameter int DELAYS = 10
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  output logic tc
);

  logic [7:0] count_reg;
  logic       run_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= 8'd0;
      run_reg   <= 1'b0;
    end else if (load) begin
      count_reg <= 8'(DELAYS - 1);
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      if (count_reg == 8'd0) begin
        run_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - 8'd1;
      end
    end
  end

  assign tc = run_reg && (count_reg == 8'd0);

endmodule

// File: rtl/mprjram_arbiter.sv
// Round-robin arbiter sharing the single-port mprjram between the Wishbone slave port
// and an accelerator port, inserting programmable BRAM wait states before each ack.
module mprjram_arbiter
  import mprjram_arb_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         DELAYS  = 10,
  parameter logic [7:0] BASE_HI = BRAM_BASE_HI
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [3:0]        acc_wstrb,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_done,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  arb_state_t state_reg;
  owner_t     last_owner_reg;
  logic       rd1_reg;
  logic       rd2_reg;
  logic       abort_reg;

  logic wb_hit;
  logic grant_wb;
  logic grant_acc;
  logic start;
  logic wait_tc;
  logic unused_adr;

  assign wb_hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == BASE_HI);
  assign grant_wb  = wb_hit && (!acc_req || (last_owner_reg == OWN_ACC));
  assign grant_acc = acc_req && !grant_wb;
  assign start     = (state_reg == IDLE) && (grant_wb || grant_acc);

  // Upper word-address bits alias within the window; byte offset is covered by sel.
  assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  mprjram_wait_cnt #(
    .DELAYS(DELAYS)
  ) u_wait_cnt (
    .clk (wb_clk_i),
    .srst(wb_rst_i),
    .load(start),
    .tc  (wait_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWN_ACC;
      rd1_reg        <= 1'b0;
      rd2_reg        <= 1'b0;
      abort_reg      <= 1'b0;
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      acc_gnt        <= 1'b0;
      acc_done       <= 1'b0;
      acc_rdata      <= '0;
      bram_en        <= 1'b0;
      bram_we        <= 4'h0;
      bram_addr      <= '0;
      bram_wdata     <= '0;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
      acc_gnt   <= 1'b0;
      wbs_ack_o <= 1'b0;
      acc_done  <= 1'b0;
      // Read data appears the cycle after bram_en; capture it one stage later.
      rd1_reg   <= 1'b0;
      rd2_reg   <= rd1_reg;
      if (rd2_reg) begin
        if (last_owner_reg == OWN_WB) begin
          wbs_dat_o <= bram_rdata;
        end else begin
          acc_rdata <= bram_rdata;
        end
      end

      case (state_reg)
        IDLE: begin
          abort_reg <= 1'b0;
          if (grant_wb) begin
            state_reg      <= BUSY_WB;
            last_owner_reg <= OWN_WB;
            bram_en        <= 1'b1;
            bram_we        <= we_mask(wbs_we_i, wbs_sel_i);
            bram_addr      <= wbs_adr_i[ADDR_W+1:2];
            bram_wdata     <= wbs_dat_i;
            rd1_reg        <= !wbs_we_i;
          end else if (grant_acc) begin
            state_reg      <= BUSY_ACC;
            last_owner_reg <= OWN_ACC;
            acc_gnt        <= 1'b1;
            bram_en        <= 1'b1;
            bram_we        <= we_mask(acc_we, acc_wstrb);
            bram_addr      <= acc_addr;
            bram_wdata     <= acc_wdata;
            rd1_reg        <= !acc_we;
          end
        end
        BUSY_WB: begin
          // A master that abandons its cycle still costs the full access time.
          if (!wbs_cyc_i) begin
            abort_reg <= 1'b1;
          end
          if (wait_tc) begin
            state_reg <= DONE;
            wbs_ack_o <= !abort_reg && wbs_cyc_i;
          end
        end
        BUSY_ACC: begin
          if (wait_tc) begin
            state_reg <= DONE;
            acc_done  <= 1'b1;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
